// File: rtl/regfile_scoreboard.sv
// Register file with a busy-bit scoreboard: two combinational read ports, one writeback port,
// and RAW/WAW hazard detection for a single issuing instruction per cycle.
module regfile_scoreboard #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_use_rs1,
  input  logic            iss_use_rs2,
  output logic            iss_accept,
  output logic            stall,
  input  logic            flush,
  output logic [AW:0]     busy_cnt
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;

  logic wb_wr;
  logic pend1, pend2, waw;

  assign wb_wr = wb_valid && (wb_rd != '0);

  // A writeback landing on the same register this cycle resolves the hazard.
  always_comb begin
    pend1 = iss_use_rs1 && (rs1 != '0) && busy_q[rs1] && !(wb_valid && (wb_rd == rs1));
    pend2 = iss_use_rs2 && (rs2 != '0) && busy_q[rs2] && !(wb_valid && (wb_rd == rs2));
    waw   = (iss_rd != '0) && busy_q[iss_rd] && !(wb_valid && (wb_rd == iss_rd));
  end

  assign stall      = reset_n && iss_valid && (pend1 || pend2 || waw);
  assign iss_accept = reset_n && iss_valid && !stall && !flush;

  always_comb begin
    rd1 = regs_q[rs1];
    if ((BYPASS != 0) && reset_n && wb_valid && (wb_rd == rs1)) begin
      rd1 = wb_data;
    end
    if (rs1 == '0) begin
      rd1 = '0;
    end
  end

  always_comb begin
    rd2 = regs_q[rs2];
    if ((BYPASS != 0) && reset_n && wb_valid && (wb_rd == rs2)) begin
      rd2 = wb_data;
    end
    if (rs2 == '0) begin
      rd2 = '0;
    end
  end

  // Clear on writeback first so that a same-edge issue set takes priority; flush beats both.
  always_comb begin
    busy_d = busy_q;
    if (wb_wr) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (iss_accept && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_d = cnt_d + (AW+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_wr) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Drives three configurations (32x32 bypass, 8x16 no bypass, 64x64 bypass) from shared stimulus
// and compares each against an array-based reference model of the register file and scoreboard.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  rs1, rs2, wb_rd, iss_rd;
  logic [63:0] wb_data;
  logic        wb_valid, iss_valid, use1, use2, flush;

  logic [31:0] a_rd1, a_rd2;
  logic        a_acc, a_stall;
  logic [5:0]  a_cnt;
  logic [15:0] b_rd1, b_rd2;
  logic        b_acc, b_stall;
  logic [3:0]  b_cnt;
  logic [63:0] c_rd1, c_rd2;
  logic        c_acc, c_stall;
  logic [6:0]  c_cnt;

  int checks   = 0;
  int failures = 0;

  int cfg_n[3]    = '{32, 8, 64};
  int cfg_xlen[3] = '{32, 16, 64};
  int cfg_byp[3]  = '{1, 0, 1};

  logic [63:0] m_reg  [3][64];
  bit          m_busy [3][64];

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .rs1(rs1[4:0]), .rs2(rs2[4:0]), .rd1(a_rd1), .rd2(a_rd2),
    .wb_valid(wb_valid), .wb_rd(wb_rd[4:0]), .wb_data(wb_data[31:0]), .iss_valid(iss_valid),
    .iss_rd(iss_rd[4:0]), .iss_use_rs1(use1), .iss_use_rs2(use2), .iss_accept(a_acc),
    .stall(a_stall), .flush(flush), .busy_cnt(a_cnt)
  );

  regfile_scoreboard #(.XLEN(16), .NREGS(8), .BYPASS(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .rs1(rs1[2:0]), .rs2(rs2[2:0]), .rd1(b_rd1), .rd2(b_rd2),
    .wb_valid(wb_valid), .wb_rd(wb_rd[2:0]), .wb_data(wb_data[15:0]), .iss_valid(iss_valid),
    .iss_rd(iss_rd[2:0]), .iss_use_rs1(use1), .iss_use_rs2(use2), .iss_accept(b_acc),
    .stall(b_stall), .flush(flush), .busy_cnt(b_cnt)
  );

  regfile_scoreboard #(.XLEN(64), .NREGS(64), .BYPASS(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .rs1(rs1), .rs2(rs2), .rd1(c_rd1), .rd2(c_rd2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .iss_use_rs1(use1), .iss_use_rs2(use2), .iss_accept(c_acc),
    .stall(c_stall), .flush(flush), .busy_cnt(c_cnt)
  );

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [63:0] dmask(input int i);
    return (cfg_xlen[i] == 64) ? '1 : ((64'd1 << cfg_xlen[i]) - 64'd1);
  endfunction

  function automatic int ad(input int i, input logic [5:0] x);
    return int'(x) % cfg_n[i];
  endfunction

  function automatic logic [63:0] exp_rd(input int i, input logic [5:0] x);
    int a = ad(i, x);
    if (!reset_n || a == 0) return 64'd0;
    if (cfg_byp[i] == 1 && wb_valid && ad(i, wb_rd) == a) return wb_data & dmask(i);
    return m_reg[i][a];
  endfunction

  function automatic bit pending(input int i, input logic use_it, input logic [5:0] x);
    int a = ad(i, x);
    return use_it && a != 0 && m_busy[i][a] && !(wb_valid && ad(i, wb_rd) == a);
  endfunction

  function automatic bit hazard(input int i);
    int d = ad(i, iss_rd);
    bit w = d != 0 && m_busy[i][d] && !(wb_valid && ad(i, wb_rd) == d);
    return pending(i, use1, rs1) || pending(i, use2, rs2) || w;
  endfunction

  function automatic bit exp_stall(input int i);
    return reset_n && iss_valid && hazard(i);
  endfunction

  function automatic bit exp_acc(input int i);
    return reset_n && iss_valid && !hazard(i) && !flush;
  endfunction

  function automatic int busy_count(input int i);
    int n = 0;
    for (int r = 0; r < 64; r++) n += int'(m_busy[i][r]);
    return n;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++)
      for (int r = 0; r < 64; r++) begin
        m_reg[i][r]  = 64'd0;
        m_busy[i][r] = 1'b0;
      end
  endfunction

  function automatic void model_edge();
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      bit acc = exp_acc(i);
      int w = ad(i, wb_rd);
      int d = ad(i, iss_rd);
      if (wb_valid && w != 0) begin
        m_reg[i][w]  = wb_data & dmask(i);
        m_busy[i][w] = 1'b0;
      end
      if (acc && d != 0) m_busy[i][d] = 1'b1;
      if (flush)
        for (int r = 0; r < 64; r++) m_busy[i][r] = 1'b0;
    end
  endfunction

  function automatic void get_obs(input int i, output logic [63:0] r1, output logic [63:0] r2,
                                  output logic acc, output logic st, output logic [63:0] cnt);
    case (i)
      0: begin r1 = 64'(a_rd1); r2 = 64'(a_rd2); acc = a_acc; st = a_stall; cnt = 64'(a_cnt); end
      1: begin r1 = 64'(b_rd1); r2 = 64'(b_rd2); acc = b_acc; st = b_stall; cnt = 64'(b_cnt); end
      default: begin
        r1 = c_rd1; r2 = c_rd2; acc = c_acc; st = c_stall; cnt = 64'(c_cnt);
      end
    endcase
  endfunction

  function automatic void check_model();
    logic [63:0] r1, r2, cnt;
    logic acc, st;
    for (int i = 0; i < 3; i++) begin
      get_obs(i, r1, r2, acc, st, cnt);
      chk($sformatf("i%0d_rd1", i), r1, exp_rd(i, rs1));
      chk($sformatf("i%0d_rd2", i), r2, exp_rd(i, rs2));
      chk($sformatf("i%0d_stall", i), 64'(st), 64'(exp_stall(i)));
      chk($sformatf("i%0d_accept", i), 64'(acc), 64'(exp_acc(i)));
      chk($sformatf("i%0d_busy_cnt", i), cnt, 64'(busy_count(i)));
      chk($sformatf("i%0d_cnt_range", i), 64'(cnt <= 64'(cfg_n[i] - 1)), 64'd1);
      chk($sformatf("i%0d_acc_on_hazard", i), 64'(acc && reset_n && iss_valid && hazard(i)), 64'd0);
    end
  endfunction

  task automatic settle();
    #2;
    check_model();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wb_valid = 0; iss_valid = 0; use1 = 0; use2 = 0; flush = 0;
    rs1 = 0; rs2 = 0; wb_rd = 0; iss_rd = 0; wb_data = 0;
  endtask

  function automatic logic [5:0] raddr();
    return ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
  endfunction

  initial begin
    model_reset();
    idle();
    reset_n = 1'b0;
    // Issue inputs active during reset must be ignored.
    iss_valid = 1; iss_rd = 3; rs1 = 5; use1 = 1;
    #1;
    settle();
    chk("reset_stall", 64'(a_stall), 64'd0);
    chk("reset_accept", 64'(a_acc), 64'd0);
    edge_step();
    @(negedge clk);
    idle();
    reset_n = 1'b1;
    edge_step();

    // Write r5, read next cycle; write r0 is ignored.
    wb_valid = 1; wb_rd = 5; wb_data = 64'hDEADBEEF;
    settle(); edge_step();
    idle(); rs1 = 5;
    settle();
    chk("r5_read", 64'(a_rd1), 64'hDEADBEEF);
    edge_step();
    wb_valid = 1; wb_rd = 0; wb_data = 64'hFFFF_FFFF;
    settle(); edge_step();
    idle(); rs1 = 0;
    settle();
    chk("r0_read", 64'(a_rd1), 64'd0);
    edge_step();

    // Bypass vs no bypass.
    wb_valid = 1; wb_rd = 7; wb_data = 64'hAAAA;
    settle(); edge_step();
    wb_valid = 1; wb_rd = 7; wb_data = 64'h1234; rs2 = 7;
    settle();
    chk("bypass_rd2", 64'(a_rd2), 64'h1234);
    chk("nobypass_rd2", 64'(b_rd2), 64'hAAAA);
    edge_step();

    // RAW stall resolved by a same-cycle writeback.
    idle(); iss_valid = 1; iss_rd = 3;
    settle();
    chk("iss3_accept", 64'(a_acc), 64'd1);
    edge_step();
    idle(); iss_valid = 1; rs1 = 3; use1 = 1;
    settle();
    chk("busy_cnt_1", 64'(a_cnt), 64'd1);
    chk("raw_stall", 64'(a_stall), 64'd1);
    wb_valid = 1; wb_rd = 3; wb_data = 64'h55;
    settle();
    chk("raw_resolved_stall", 64'(a_stall), 64'd0);
    chk("raw_resolved_accept", 64'(a_acc), 64'd1);
    edge_step();

    // Same-edge writeback and issue to r4: set wins, data written.
    idle(); wb_valid = 1; wb_rd = 4; wb_data = 64'h4444; iss_valid = 1; iss_rd = 4;
    settle(); edge_step();
    idle(); iss_valid = 1; iss_rd = 4; rs1 = 4;
    settle();
    chk("r4_data", 64'(a_rd1), 64'h4444);
    chk("r4_waw_stall", 64'(a_stall), 64'd1);
    edge_step();
    idle(); iss_valid = 1; iss_rd = 5; settle(); edge_step();
    idle(); iss_valid = 1; iss_rd = 6; settle(); edge_step();
    idle(); flush = 1; iss_valid = 1; iss_rd = 9;
    settle();
    chk("busy_cnt_3", 64'(a_cnt), 64'd3);
    chk("flush_accept", 64'(a_acc), 64'd0);
    edge_step();
    idle();
    settle();
    chk("flush_cnt", 64'(a_cnt), 64'd0);
    edge_step();

    // Asynchronous reset between edges.
    iss_valid = 1; iss_rd = 1; settle(); edge_step();
    iss_valid = 1; iss_rd = 2; settle(); edge_step();
    idle(); iss_valid = 1; iss_rd = 10; rs1 = 4;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_cnt", 64'(a_cnt), 64'd0);
    chk("async_rd1", 64'(a_rd1), 64'd0);
    chk("async_accept", 64'(a_acc), 64'd0);
    settle();
    edge_step();
    @(negedge clk);
    reset_n = 1'b1;
    idle(); iss_valid = 1; iss_rd = 2;
    settle();
    chk("post_reset_accept", 64'(a_acc), 64'd1);
    edge_step();
    idle();
    settle();
    chk("post_reset_cnt", 64'(a_cnt), 64'd1);
    edge_step();

    // Random issue/writeback traffic.
    for (int n = 0; n < 3000; n++) begin
      wb_valid  = ($urandom_range(0, 1) == 1);
      wb_rd     = raddr();
      wb_data   = {$urandom(), $urandom()};
      iss_valid = ($urandom_range(0, 9) < 6);
      iss_rd    = raddr();
      rs1       = raddr();
      rs2       = raddr();
      use1      = ($urandom_range(0, 1) == 1);
      use2      = ($urandom_range(0, 1) == 1);
      flush     = ($urandom_range(0, 15) == 0);
      settle();
      edge_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of each register.
REQ-002 SHALL have parameter NREGS, default 32, register count; legal values are powers of two from 4 to 64.
REQ-003 SHALL have parameter BYPASS, default 1; 1 means a same-cycle writeback is forwarded to the read ports, 0 means no forwarding.
REQ-004 SHALL define AW = clog2(NREGS) as a derived localparam, not overridable.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 rs1, rs2  in  AW each  read addresses; also the source operands checked for the issuing instruction.
REQ-008 rd1, rd2  out  XLEN each  read data, combinational from the addresses.
REQ-009 wb_valid  in  1  writeback strobe.
REQ-010 wb_rd  in  AW  writeback destination.
REQ-011 wb_data  in  XLEN  writeback data.
REQ-012 iss_valid  in  1  an instruction requests issue this cycle.
REQ-013 iss_rd  in  AW  destination of the issuing instruction.
REQ-014 iss_use_rs1, iss_use_rs2  in  1 each  the issuing instruction reads rs1 / rs2.
REQ-015 iss_accept  out  1  issue accepted this cycle.
REQ-016 stall  out  1  issue blocked by a hazard.
REQ-017 flush  in  1  synchronous clear of all busy bits.
REQ-018 busy_cnt  out  AW+1  number of registers currently marked busy.

Function
REQ-019 Register 0 SHALL always read 0, SHALL ignore writes, and SHALL never become busy.
REQ-020 On a rising edge with wb_valid=1 and wb_rd!=0, reg[wb_rd] SHALL load wb_data and busy[wb_rd] SHALL clear. This applies even if the register was not busy.
REQ-021 Read data: rdN = 0 if rsN=0; else wb_data if BYPASS=1, wb_valid=1 and wb_rd=rsN; else reg[rsN].
REQ-022 A source register is pending when iss_use_rsN=1, rsN!=0 and busy[rsN]=1, unless wb_valid=1 and wb_rd=rsN in the same cycle, in which case it is not pending.
REQ-023 A WAW hazard exists when iss_rd!=0 and busy[iss_rd]=1, unless a same-cycle writeback to iss_rd clears it.
REQ-024 stall SHALL equal iss_valid AND (either source pending OR WAW hazard), combinationally.
REQ-025 iss_accept SHALL equal iss_valid AND NOT stall AND NOT flush.
REQ-026 On a rising edge with iss_accept=1 and iss_rd!=0, busy[iss_rd] SHALL set.
REQ-027 If a set and a clear hit the same register on one edge, the set SHALL win.
REQ-028 flush=1 SHALL clear every busy bit on the next edge and override any issue set on that edge. A writeback on that edge SHALL still write data.
REQ-029 busy_cnt SHALL be a registered population count of the busy bits, consistent with the busy vector after each edge, range 0..NREGS-1.
REQ-030 Latency: a write is visible via reg[] one cycle after the edge; with BYPASS=1 it is also visible in the same cycle. A busy bit changes one edge after the issue or writeback.
REQ-031 Inputs with valid=0 SHALL be don't-care and SHALL cause no state change.

Reset
REQ-032 While reset_n=0: all registers 0, all busy bits 0, busy_cnt 0.
REQ-033 While reset_n=0: stall and iss_accept SHALL be 0 regardless of the issue inputs.
REQ-034 Assertion of reset_n=0 mid-operation SHALL take effect immediately, without waiting for a clock edge.
REQ-035 Deassertion of reset_n SHALL be honoured only at a clock edge; the first state update occurs on the first edge after reset_n=1.

Verification
REQ-036 Reset, then write 0xDEADBEEF to r5, then read rs1=5 the next cycle -> rd1=0xDEADBEEF. Write to r0, then read rs1=0 -> 0.
REQ-037 BYPASS=1: wb_rd=7, wb_data=0x1234, rs2=7 in the same cycle -> rd2=0x1234 that cycle. With BYPASS=0 -> rd2 holds the old value.
REQ-038 Issue iss_rd=3 (accepted) -> busy_cnt=1. Next cycle issue with rs1=3, iss_use_rs1=1 -> stall=1. Writeback to r3 in that cycle -> stall=0, iss_accept=1.
REQ-039 On one edge, writeback to r4 and accepted issue with iss_rd=4 -> busy[4]=1 and reg[4] updated. Flush with 3 busy registers -> busy_cnt=0 next cycle and a concurrent issue is not set.
REQ-040 Pull reset_n low between edges while registers are busy -> busy_cnt and all registers read 0 immediately. Release reset_n, then the first issue is accepted on the following edge.
REQ-041 Regression SHALL run XLEN=16, NREGS=8 and XLEN=64, NREGS=64 with random issue/writeback against a reference model. Checks: busy_cnt at most NREGS-1, and no accepted issue while a hazard exists.
